uart_tx_fifo_param: RTL and testbench



---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_tx_fifo_param_if.sv | 27 ++
 rtl/uart_sync_fifo.sv | 87 ++++++++
 rtl/uart_tx_fifo_param.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   - Parity mode constants (PAR_NONE / PAR_EVEN / PAR_ODD)
//   - Transmit FSM state encoding
//   - calc_divisor(): clock cycles per bit, integer floor of clk_hz / baud
//   - clog2(): ceiling log2 for sizing counters and pointers
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    // A zero baud yields 0, which then fails the legality check in the top.
    function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                                 input int unsigned baud);
        if (baud == 0) begin
            return 0;
        end
        return clk_hz / baud;
    endfunction

    // Returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned    result;
        longint unsigned pow;
        result = 0;
        pow    = 1;
        while (pow < longint'(value)) begin
            pow    = pow * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// Valid/ready write port of the UART transmitter.
//   in_data  : word to transmit (producer -> transmitter)
//   in_valid : producer offers in_data
//   in_ready : transmitter FIFO can accept; a word transfers when both are
//              high at a rising clock edge
// master = producer side, slave = transmitter side.
interface uart_tx_fifo_param_if #(
    parameter int unsigned DATA_BITS = 8
);

    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, single clock, synchronous active-low reset.
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset; flushes pointers and level
//   wr_en   : write request; ignored while full (no bypass through a pop)
//   wr_data : write data
//   full    : level == DEPTH
//   rd_en   : pop request; ignored while empty
//   rd_data : head entry (combinational read of the head slot)
//   empty   : level == 0
//   level   : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    output logic                    full,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   level
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_wr;
    logic             do_rd;

    // Full/empty come from the registered level only, so a refused write
    // stays refused even if a pop happens in the same cycle.
    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_wr    = wr_en & ~full;
        do_rd    = rd_en & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;

        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({do_wr, do_rd})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with an input FIFO.
//   user_clock    : sole clock, rising edge
//   rst           : synchronous active-low reset; abandons any frame in flight
//   in_if         : valid/ready write port (slave side)
//   usb_rs232_txd : serial line, idles high, driven straight from a flop
//   tx_busy       : high from the pop of a word until its last stop-bit tick
//   fifo_level    : words queued, excluding the frame in flight
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stops.
// Frames run back to back while the FIFO holds data.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 40000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          user_clock,
    input  logic                          rst,
    uart_tx_fifo_param_if.slave           in_if,
    output logic                          usb_rs232_txd,
    output logic                          tx_busy,
    output logic [clog2(FIFO_DEPTH):0]    fifo_level
);

    localparam int unsigned DIVISOR = calc_divisor(CLK_HZ, BAUD);
    localparam int unsigned CNT_W   = (clog2(DIVISOR) < 1) ? 1 : clog2(DIVISOR);
    localparam int unsigned IDX_W   = clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0] BIT_MAX  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_MAX = 1'(STOP_BITS - 1);

    if (DIVISOR < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > PAR_ODD ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_check
        $error("uart_tx_fifo_param: illegal parameter combination");
    end

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 busy_q, busy_d;
    logic                 txd_q, txd_d;

    logic                 tick;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (user_clock),
        .rst_ni  (rst),
        .wr_en   (in_if.in_valid),
        .wr_data (in_if.in_data),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_if.in_ready = ~fifo_full;
    assign usb_rs232_txd  = txd_q;
    assign tx_busy        = busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        busy_d  = busy_q;
        pop     = 1'b0;
        tick    = (cnt_q == CNT_MAX);

        if (state_q != StIdle) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == BIT_MAX) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    if (stop_q == STOP_MAX) begin
                        stop_d = 1'b0;
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A pop always starts a fresh frame with a cleared baud counter, so
        // back-to-back frames keep exact bit timing.
        if (pop) begin
            state_d = StStart;
            cnt_d   = '0;
            idx_d   = '0;
            stop_d  = 1'b0;
            shreg_d = fifo_rd_data;
            par_d   = (^fifo_rd_data) ^ (PARITY == PAR_ODD);
            busy_d  = 1'b1;
        end

        // The line follows the current state one cycle later through txd_q,
        // keeping the pin free of any combinational path.
        unique case (state_q)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shreg_q[0];
            StParity: txd_d = par_q;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge user_clock) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            busy_q  <= busy_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: three instances (8N1, 8E1, 7O2) sharing one
// clock and reset. Single frames come from a vector table; the burst,
// back-pressure and mid-frame reset cases are hand-written sequences.
module tb_uart_tx_fifo_param;

    localparam int D = 347;  // 40 MHz / 115200, floored

    logic clk;
    logic rst;
    int   cyc;
    int   sel;
    int   checks;
    int   failures;
    int   acc_edge [8];

    logic       txd0, txd1, txd2;
    logic       busy0, busy1, busy2;
    logic [2:0] lvl0, lvl1, lvl2;

    logic       mon_txd;
    logic       mon_busy;
    logic       mon_ready;
    logic [2:0] mon_level;

    uart_tx_fifo_param_if #(.DATA_BITS(8)) if0 ();
    uart_tx_fifo_param_if #(.DATA_BITS(8)) if1 ();
    uart_tx_fifo_param_if #(.DATA_BITS(7)) if2 ();

    uart_tx_fifo_param u_dut0 (
        .user_clock    (clk),
        .rst           (rst),
        .in_if         (if0),
        .usb_rs232_txd (txd0),
        .tx_busy       (busy0),
        .fifo_level    (lvl0)
    );

    uart_tx_fifo_param #(.PARITY(1)) u_dut1 (
        .user_clock    (clk),
        .rst           (rst),
        .in_if         (if1),
        .usb_rs232_txd (txd1),
        .tx_busy       (busy1),
        .fifo_level    (lvl1)
    );

    uart_tx_fifo_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut2 (
        .user_clock    (clk),
        .rst           (rst),
        .in_if         (if2),
        .usb_rs232_txd (txd2),
        .tx_busy       (busy2),
        .fifo_level    (lvl2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        case (sel)
            1: begin
                mon_txd = txd1; mon_busy = busy1; mon_ready = if1.in_ready; mon_level = lvl1;
            end
            2: begin
                mon_txd = txd2; mon_busy = busy2; mon_ready = if2.in_ready; mon_level = lvl2;
            end
            default: begin
                mon_txd = txd0; mon_busy = busy0; mon_ready = if0.in_ready; mon_level = lvl0;
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [8:0] d);
        case (s)
            1:       begin if1.in_valid = v; if1.in_data = d[7:0]; end
            2:       begin if2.in_valid = v; if2.in_data = d[6:0]; end
            default: begin if0.in_valid = v; if0.in_data = d[7:0]; end
        endcase
    endtask

    // Called at a negedge; returns at the negedge just after the last
    // handshake edge. acc_edge[w] records the edge that took word w.
    task automatic push_seq(input int s, input int n, input logic [8:0] first);
        int w;
        int guard;
        w     = 0;
        guard = 0;
        drive(s, 1'b1, first);
        while (w < n && guard < 30000) begin
            if (mon_ready) begin
                acc_edge[w] = cyc + 1;
                w = w + 1;
            end
            @(negedge clk);
            guard = guard + 1;
            if (w < n) drive(s, 1'b1, first + 9'(w));
            else       drive(s, 1'b0, 9'd0);
        end
        drive(s, 1'b0, 9'd0);
        check("push_done", w, n);
    endtask

    // Entered at the negedge after handshake edge A of a lone word.
    task automatic run_frame(input string name, input int nbits, input logic [11:0] exp);
        check({name, "_line_at_wr"}, mon_txd, 1);
        @(negedge clk);
        check({name, "_line_at_pop"}, mon_txd, 1);
        check({name, "_busy_at_pop"}, mon_busy, 1);
        @(negedge clk);
        for (int j = 0; j < nbits * D; j++) begin
            if (j % D == 0 || j % D == D - 1) check({name, "_bit"}, mon_txd, exp[j / D]);
            @(negedge clk);
        end
        check({name, "_line_after"}, mon_txd, 1);
        check({name, "_busy_after"}, mon_busy, 0);
        check({name, "_level_after"}, mon_level, 0);
    endtask

    // Six back-to-back 8N1 frames carrying 1..6, plus the full/pop window.
    task automatic burst_monitor();
        int         g;
        int         a;
        int         k;
        int         f;
        int         b;
        logic [7:0] wd;
        logic       e;
        g = 0;
        while (mon_txd !== 1'b0 && g < 100) begin
            @(negedge clk);
            g = g + 1;
        end
        a = acc_edge[0];
        check("burst_first_fall", cyc, a + 2);
        for (int j = 0; j < 60 * D; j++) begin
            k  = j / D;
            f  = k / 10;
            b  = k % 10;
            wd = 8'(f + 1);
            e  = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : wd[b - 1];
            if (j % D == 0 || j % D == D - 1) check("burst_bit", mon_txd, e);
            if (cyc == a + 4) begin
                check("burst_full_ready", mon_ready, 0);
                check("burst_full_level", mon_level, 4);
            end
            if (cyc == a + 1 + 10 * D) begin
                check("pop_refuse_level", mon_level, 3);
                check("pop_refuse_ready", mon_ready, 1);
            end
            if (cyc == a + 2 + 10 * D) check("pop_next_level", mon_level, 4);
            @(negedge clk);
        end
        check("burst_line_after", mon_txd, 1);
        check("burst_busy_after", mon_busy, 0);
        check("burst_level_after", mon_level, 0);
    endtask

    typedef struct {
        int          dut;
        logic [8:0]  data;
        int          nbits;
        logic [11:0] exp_bits;  // bit k = line value during bit period k
        string       name;
    } frame_vec_t;

    frame_vec_t vecs [3];

    initial begin
        int a;
        int target;
        int lows;
        int busys;

        vecs[0] = '{dut: 0, data: 9'h042, nbits: 10, exp_bits: 12'h284, name: "f8n1_42"};
        vecs[1] = '{dut: 1, data: 9'h007, nbits: 11, exp_bits: 12'h60E, name: "f8e1_07"};
        vecs[2] = '{dut: 2, data: 9'h07F, nbits: 11, exp_bits: 12'h6FE, name: "f7o2_7f"};

        checks   = 0;
        failures = 0;
        sel      = 0;
        rst      = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 9'd0);
        repeat (3) @(negedge clk);

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_line", mon_txd, 1);
            check("rst_busy", mon_busy, 0);
            check("rst_ready", mon_ready, 1);
            check("rst_level", mon_level, 0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Single frames from the table.
        foreach (vecs[i]) begin
            sel = vecs[i].dut;
            @(negedge clk);
            push_seq(vecs[i].dut, 1, vecs[i].data);
            run_frame(vecs[i].name, vecs[i].nbits, vecs[i].exp_bits);
        end

        // Burst of six with in_valid held; the sixth waits for a pop.
        sel = 0;
        @(negedge clk);
        foreach (acc_edge[i]) acc_edge[i] = -1;
        fork
            push_seq(0, 6, 9'd1);
            burst_monitor();
        join
        a = acc_edge[0];
        for (int w = 1; w < 5; w++) check("burst_accept_edge", acc_edge[w], a + w);
        check("sixth_accept_edge", acc_edge[5], a + 2 + 10 * D);

        // Reset during data bit 3 with two words queued.
        @(negedge clk);
        push_seq(0, 3, 9'd1);
        a      = acc_edge[0];
        target = a + 2 + 4 * D + D / 2;
        while (cyc < target) @(negedge clk);
        check("pre_rst_level", mon_level, 2);
        check("pre_rst_busy", mon_busy, 1);
        check("pre_rst_bit3", mon_txd, 0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_line", mon_txd, 1);
        check("mid_rst_busy", mon_busy, 0);
        check("mid_rst_level", mon_level, 0);
        check("mid_rst_ready", mon_ready, 1);
        rst   = 1'b1;
        lows  = 0;
        busys = 0;
        for (int j = 0; j < 3 * D; j++) begin
            @(negedge clk);
            if (mon_txd !== 1'b1) lows = lows + 1;
            if (mon_busy !== 1'b0) busys = busys + 1;
        end
        check("post_rst_line_lows", lows, 0);
        check("post_rst_busy_cycles", busys, 0);
        check("post_rst_level", mon_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
